// File: rtl/spi_flash_xip_slave.sv
// spi_flash_xip_slave
// Clock-oversampled SPI mode-0 flash slave answering the READ (0x03) command.
// SPI pins are synchronised into the system clock domain. After the opcode and
// a 24-bit address, 32-bit words are fetched over a req/ack port one word ahead
// and shifted out MSB-first, with the address auto-incrementing while SS is low.

module spi_flash_xip_slave #(
    parameter logic [7:0] READ_CMD = 8'h03
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_ss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        cmd_err,
    output logic        late_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
    } state_t;

    // Synchronised pins and registered SCK edge pulses.
    logic sck_meta, sck_sync, sck_prev;
    logic ss_meta, ss_sync;
    logic mosi_meta, mosi_sync;
    logic sck_rise, sck_fall;

    // Protocol state.
    state_t      state;
    logic [5:0]  bit_cnt;
    logic [23:0] sh_in;
    logic [31:0] sh_out;
    logic [23:0] addr;

    // One-word prefetch buffer and memory-port bookkeeping.
    logic [31:0] word_buf;
    logic        buf_valid;
    logic        fetch_pend;   // a fetch of 'addr' is waiting for the port to free up
    logic        discard;      // data of the request in flight must be dropped

    // Derived values used by the main sequential block.
    logic        ack_take;
    logic [23:0] sh_in_next;
    logic [23:0] rx_addr;
    logic [23:0] addr_inc;
    logic [31:0] next_word;
    logic        next_valid;

    assign ack_take   = mem_req & mem_ack & ~discard;
    assign sh_in_next = {sh_in[22:0], mosi_sync};
    assign rx_addr    = {sh_in_next[23:2], 2'b00};
    assign addr_inc   = addr + 24'd4;
    // A word acknowledged in the same cycle it is needed still counts as on time.
    assign next_word  = ack_take ? mem_rdata : word_buf;
    assign next_valid = ack_take | buf_valid;

    // Two-flop synchronisers on the SPI pins plus a third SCK stage for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so each stage samples the
            // previous stage's old value; blocking '=' would collapse the chain.
            sck_meta  <= spi_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ss_meta   <= spi_ss;
            ss_sync   <= ss_meta;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
            sck_rise  <= sck_sync & ~sck_prev;
            sck_fall  <= ~sck_sync & sck_prev;
        end
    end

    // Protocol FSM, shift registers, prefetch buffer and memory request port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the word buffer is a plain register, so it is reset with
            // everything else; only true RAM arrays are left without reset.
            state      <= S_IDLE;
            bit_cnt    <= 6'd0;
            sh_in      <= 24'd0;
            sh_out     <= 32'd0;
            addr       <= 24'd0;
            word_buf   <= 32'd0;
            buf_valid  <= 1'b0;
            fetch_pend <= 1'b0;
            discard    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 24'd0;
            spi_miso   <= 1'b0;
            cmd_err    <= 1'b0;
            late_flag  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;

            // Memory port: retire an acked request, or launch a deferred fetch.
            // The FSM below may override these assignments in the same cycle.
            if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                discard <= 1'b0;
                if (!discard) begin
                    word_buf  <= mem_rdata;
                    buf_valid <= 1'b1;
                end
            end else if (fetch_pend && !mem_req) begin
                mem_req    <= 1'b1;
                mem_addr   <= addr;
                fetch_pend <= 1'b0;
            end

            if (ss_sync) begin
                // Deselect aborts everything; a request already in flight runs
                // to its ack but its data is thrown away.
                state      <= S_IDLE;
                bit_cnt    <= 6'd0;
                sh_in      <= 24'd0;
                sh_out     <= 32'd0;
                buf_valid  <= 1'b0;
                fetch_pend <= 1'b0;
                spi_miso   <= 1'b0;
                if (mem_req && !mem_ack) begin
                    discard <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_CMD;
                        bit_cnt <= 6'd0;
                    end

                    S_CMD: begin
                        if (sck_rise) begin
                            sh_in <= sh_in_next;
                            if (bit_cnt == 6'd7) begin
                                bit_cnt <= 6'd0;
                                if (sh_in_next[7:0] == READ_CMD) begin
                                    state <= S_ADDR;
                                end else begin
                                    state   <= S_IGNORE;
                                    cmd_err <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end

                    S_ADDR: begin
                        if (sck_rise) begin
                            sh_in <= sh_in_next;
                            if (bit_cnt == 6'd23) begin
                                bit_cnt <= 6'd0;
                                addr    <= rx_addr;
                                state   <= S_DATA;
                                // Hold off while a previous transaction's request is pending.
                                if (!mem_req) begin
                                    mem_req  <= 1'b1;
                                    mem_addr <= rx_addr;
                                end else begin
                                    fetch_pend <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end

                    S_DATA: begin
                        if (sck_fall) begin
                            bit_cnt <= {1'b0, bit_cnt[4:0] + 5'd1};
                            if (bit_cnt[4:0] == 5'd0) begin
                                if (next_valid) begin
                                    sh_out   <= next_word;
                                    spi_miso <= next_word[31];
                                end else begin
                                    // Data missed its slot: send zeros and make sure the
                                    // stale word still in flight does not land later.
                                    sh_out    <= 32'd0;
                                    spi_miso  <= 1'b0;
                                    late_flag <= 1'b1;
                                    if (mem_req && !mem_ack) begin
                                        discard <= 1'b1;
                                    end
                                end
                                buf_valid <= 1'b0;
                                addr      <= addr_inc;
                                if (!mem_req) begin
                                    mem_req    <= 1'b1;
                                    mem_addr   <= addr_inc;
                                    fetch_pend <= 1'b0;
                                end else begin
                                    fetch_pend <= 1'b1;
                                end
                            end else begin
                                sh_out   <= {sh_out[30:0], 1'b0};
                                spi_miso <= sh_out[30];
                            end
                        end
                    end

                    S_IGNORE: begin
                        spi_miso <= 1'b0;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_xip_slave.sv
// Directed bench for spi_flash_xip_slave: an SPI mode-0 master driven from tasks
// and a req/ack memory that returns {8'hA5, addr} (0xDEADBEEF at 0x000010)
// after a programmable delay.

module tb_spi_flash_xip_slave;

    localparam int HALF = 6;   // SCK half-period in system clocks

    logic        clock = 1'b0;
    logic        reset;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        cmd_err;
    logic        late_flag;

    int vectors     = 0;
    int miscompares = 0;

    int          ack_delay = 1;
    int          mem_age   = 0;
    logic [23:0] req_log[$];
    int          err_pulses = 0;
    int          miso_hi    = 0;

    spi_flash_xip_slave dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .cmd_err   (cmd_err),
        .late_flag (late_flag)
    );

    always #5 clock = ~clock;

    // Memory model: log each new request, ack it once it has aged ack_delay clocks.
    always @(negedge clock) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (mem_age == 0) req_log.push_back(mem_addr);
            if (mem_age >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = (mem_addr == 24'h000010) ? 32'hDEADBEEF : {8'hA5, mem_addr};
            end
            mem_age = mem_age + 1;
        end else begin
            mem_age = 0;
        end
    end

    // Event counters read as before/after snapshots by the directed sequence.
    always @(negedge clock) begin
        if (cmd_err)  err_pulses = err_pulses + 1;
        if (spi_miso) miso_hi    = miso_hi + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic xfer(input logic b, output logic m);
        spi_mosi = b;
        wait_clk(HALF);
        m = spi_miso;
        spi_sck = 1'b1;
        wait_clk(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic send(input logic [23:0] v, input int n);
        logic m;
        for (int i = n - 1; i >= 0; i--) xfer(v[i], m);
    endtask

    task automatic recv(output logic [31:0] w);
        logic m;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            xfer(1'b0, m);
            w = {w[30:0], m};
        end
    endtask

    task automatic ss_start();
        spi_ss = 1'b0;
        wait_clk(8);
    endtask

    task automatic ss_stop();
        wait_clk(HALF);
        spi_ss = 1'b1;
        wait_clk(10);
    endtask

    initial begin
        logic [31:0] w0, w1, w2;
        int base, e0, m0;
        logic m;

        reset    = 1'b0;
        spi_sck  = 1'b0;
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(3);
        check("reset_miso",     {31'd0, spi_miso},  32'd0);
        check("reset_mem_req",  {31'd0, mem_req},   32'd0);
        check("reset_mem_addr", {8'd0, mem_addr},   32'd0);
        check("reset_cmd_err",  {31'd0, cmd_err},   32'd0);
        check("reset_late",     {31'd0, late_flag}, 32'd0);
        reset = 1'b1;
        wait_clk(3);

        // Single read at 0x000010.
        base = req_log.size();
        ss_start();
        send(24'h000003, 8);
        send(24'h000010, 24);
        recv(w0);
        ss_stop();
        check("single_req_addr", {8'd0, req_log[base]}, 32'h0000_0010);
        check("single_data",     w0,                    32'hDEADBEEF);
        check("single_late",     {31'd0, late_flag},    32'd0);

        // Continuous read of three words from 0x000100.
        wait_clk(10);
        base = req_log.size();
        ss_start();
        send(24'h000003, 8);
        send(24'h000100, 24);
        recv(w0);
        recv(w1);
        recv(w2);
        ss_stop();
        check("cont_word0", w0, 32'hA500_0100);
        check("cont_word1", w1, 32'hA500_0104);
        check("cont_word2", w2, 32'hA500_0108);
        check("cont_req0", {8'd0, req_log[base]},     32'h0000_0100);
        check("cont_req1", {8'd0, req_log[base + 1]}, 32'h0000_0104);
        check("cont_req2", {8'd0, req_log[base + 2]}, 32'h0000_0108);
        check("cont_req3", {8'd0, req_log[base + 3]}, 32'h0000_010C);
        check("cont_late", {31'd0, late_flag},        32'd0);

        // Address wrap from 0xFFFFFE (aligned down to 0xFFFFFC).
        wait_clk(10);
        base = req_log.size();
        ss_start();
        send(24'h000003, 8);
        send(24'hFFFFFE, 24);
        recv(w0);
        ss_stop();
        check("wrap_req0", {8'd0, req_log[base]},     32'h00FF_FFFC);
        check("wrap_req1", {8'd0, req_log[base + 1]}, 32'h0000_0000);
        check("wrap_data", w0,                        32'hA5FF_FFFC);

        // Unsupported opcode 0x9F followed by 56 clocks of ones.
        wait_clk(20);
        base = req_log.size();
        e0   = err_pulses;
        m0   = miso_hi;
        ss_start();
        send(24'h00009F, 8);
        for (int i = 0; i < 56; i++) xfer(1'b1, m);
        ss_stop();
        check("bad_cmd_err_pulses", err_pulses - e0,      32'd1);
        check("bad_miso_high",      miso_hi - m0,         32'd0);
        check("bad_mem_reqs",       req_log.size() - base, 32'd0);

        // Abort after 12 address bits, then a normal read.
        wait_clk(10);
        base = req_log.size();
        ss_start();
        send(24'h000003, 8);
        send(24'h000000, 12);
        ss_stop();
        check("abort_no_req", req_log.size() - base, 32'd0);
        ss_start();
        send(24'h000003, 8);
        send(24'h000010, 24);
        recv(w0);
        ss_stop();
        check("abort_next_data", w0, 32'hDEADBEEF);

        // Late data: memory holds every ack for 100 clocks.
        wait_clk(10);
        ack_delay = 100;
        ss_start();
        send(24'h000003, 8);
        send(24'h000200, 24);
        recv(w0);
        check("late_word0", w0,                 32'h0000_0000);
        check("late_flag",  {31'd0, late_flag}, 32'd1);
        recv(w1);
        ss_stop();
        check("late_word1", w1, 32'hA500_0204);
        ack_delay = 1;
        wait_clk(300);
        check("late_sticky", {31'd0, late_flag}, 32'd1);

        // Reset in the middle of DATA while a request is held high.
        ack_delay = 1000;
        ss_start();
        send(24'h000003, 8);
        send(24'h000300, 24);
        for (int i = 0; i < 4; i++) xfer(1'b0, m);
        check("mid_req_high",  {31'd0, mem_req}, 32'd1);
        check("mid_req_addr",  {8'd0, mem_addr}, 32'h0000_0300);
        #2;
        reset = 1'b0;
        #1;
        check("rst_miso",     {31'd0, spi_miso},  32'd0);
        check("rst_mem_req",  {31'd0, mem_req},   32'd0);
        check("rst_mem_addr", {8'd0, mem_addr},   32'd0);
        check("rst_cmd_err",  {31'd0, cmd_err},   32'd0);
        check("rst_late",     {31'd0, late_flag}, 32'd0);
        spi_ss    = 1'b1;
        spi_sck   = 1'b0;
        ack_delay = 1;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
